// File: rtl/float12_pkg.sv
// Shared definitions for the 12-bit float format {sgn, exp[4:0] bias 15, man[5:0], hidden 1}.
// Used by the divider, the multiplier output stage and the common round/saturate block.
package float12_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 6;
  localparam int BIAS  = 15;

  localparam logic [11:0] F12_ZERO    = 12'h000;
  localparam logic [10:0] F12_SAT_MAG = 11'h7FF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_NORM = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Division by zero wins over a zero dividend.
  function automatic logic [11:0] f12_special(input logic sgn, input logic div_by_zero);
    return div_by_zero ? {sgn, F12_SAT_MAG} : F12_ZERO;
  endfunction

endpackage

// File: rtl/float12_round.sv
// Combinational {sgn, signed exp, 6 mantissa bits + round bit} -> 12-bit float with flush,
// saturation and round-half-up; zero latency, no handshake.
module float12_round
  import float12_pkg::*;
(
  input  logic              sgn_i,
  input  logic signed [6:0] exp_i,
  input  logic        [6:0] man_i,
  output logic       [11:0] res_o
);

  logic [11:0] sum;

  always_comb begin
    sum   = '0;
    res_o = F12_ZERO;
    if (exp_i <= 7'sd0) begin
      res_o = F12_ZERO;
    end else if (exp_i > 7'sd31) begin
      res_o = {sgn_i, F12_SAT_MAG};
    end else if ({exp_i[4:0], man_i[6:1]} == F12_SAT_MAG) begin
      // Already at the largest magnitude: rounding up would wrap to zero.
      res_o = {sgn_i, F12_SAT_MAG};
    end else begin
      sum   = {exp_i[4:0], man_i} + 12'd1;
      res_o = {sgn_i, sum[11:1]};
    end
  end

endmodule

// File: rtl/div_12.sv
// Iterative 12-bit float divider data_1_i / data_2_i, one operation in flight; 11 cycles accept->valid_o
// (1 with DIV_12_EARLY_OUT_EN for zero operands); result held in DONE until ready_i, ready_o only in IDLE.
module div_12
  import float12_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [11:0] data_1_i,
  input  logic [11:0] data_2_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [11:0] data_div_o,
  output logic        valid_o,
  input  logic        ready_i
);

  localparam int MW = MAN_W + 1;

  state_e              state_q, state_d;
  logic                sgn_q, sgn_d;
  logic       [MW-1:0] ma_q, ma_d;
  logic       [MW-1:0] mb_q, mb_d;
  logic signed   [6:0] e_q, e_d;
  logic                za_q, za_d;
  logic                zb_q, zb_d;
  logic          [7:0] rem_q, rem_d;
  logic          [8:0] quo_q, quo_d;
  logic          [3:0] cnt_q, cnt_d;
  logic         [11:0] res_q, res_d;
  logic                vld_q, vld_d;

  logic                za_in, zb_in;
  logic                q_bit;
  logic          [7:0] diff;
  logic          [6:0] norm_m7;
  logic signed   [6:0] norm_e;
  logic         [11:0] round_res;

  assign za_in = (data_1_i[10:0] == 11'd0);
  assign zb_in = (data_2_i[10:0] == 11'd0);

  // One restoring step: the partial remainder never exceeds 2*divisor-1, so 8 bits suffice.
  assign q_bit = (rem_q >= {1'b0, mb_q});
  assign diff  = q_bit ? (rem_q - {1'b0, mb_q}) : rem_q;

  assign norm_m7 = quo_q[8] ? quo_q[7:1] : quo_q[6:0];
  assign norm_e  = quo_q[8] ? e_q : (e_q - 7'sd1);

  float12_round u_round (
    .sgn_i (sgn_q),
    .exp_i (norm_e),
    .man_i (norm_m7),
    .res_o (round_res)
  );

  always_comb begin
    state_d = state_q;
    sgn_d   = sgn_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    e_d     = e_q;
    za_d    = za_q;
    zb_d    = zb_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    vld_d   = vld_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          sgn_d   = data_1_i[11] ^ data_2_i[11];
          ma_d    = {1'b1, data_1_i[MAN_W-1:0]};
          mb_d    = {1'b1, data_2_i[MAN_W-1:0]};
          e_d     = 7'({2'b00, data_1_i[10:MAN_W]}) - 7'({2'b00, data_2_i[10:MAN_W]}) + 7'(BIAS);
          za_d    = za_in;
          zb_d    = zb_in;
          rem_d   = {1'b0, data_1_i[10:MAN_W] == 5'd0 ? 1'b1 : 1'b1, data_1_i[MAN_W-1:0]};
          quo_d   = '0;
          cnt_d   = 4'd8;
          state_d = S_DIV;
`ifdef DIV_12_EARLY_OUT_EN
          if (za_in || zb_in) begin
            res_d   = f12_special(data_1_i[11] ^ data_2_i[11], zb_in);
            vld_d   = 1'b1;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_DIV: begin
        quo_d = {quo_q[7:0], q_bit};
        rem_d = {diff[6:0], 1'b0};
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        res_d   = (za_q || zb_q) ? f12_special(sgn_q, zb_q) : round_res;
        vld_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (ready_i) begin
          vld_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      sgn_q   <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      e_q     <= '0;
      za_q    <= 1'b0;
      zb_q    <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      res_q   <= F12_ZERO;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      e_q     <= e_d;
      za_q    <= za_d;
      zb_q    <= zb_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
    end
  end

  assign ready_o    = (state_q == S_IDLE);
  assign data_div_o = res_q;
  assign valid_o    = vld_q;

endmodule

// File: tb/tb_div_12.sv
// Directed and random checks of div_12 against an arithmetic reference of the 12-bit float divide.
module tb_div_12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] data_1 = '0;
  logic [11:0] data_2 = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [11:0] data_div;
  logic        valid_o;
  logic        ready_i = 1'b1;

  int errors = 0;
  int checks = 0;
  int busy_viol = 0;

`ifdef DIV_12_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 11;
`endif

  div_12 dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .data_1_i   (data_1),
    .data_2_i   (data_2),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_div_o (data_div),
    .valid_o    (valid_o),
    .ready_i    (ready_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: real-valued meaning of the format, computed with integer arithmetic.
  function automatic logic [11:0] model(input logic [11:0] a, input logic [11:0] b);
    logic s;
    int ea, eb, ma, mb, e, q, m7, v;
    logic [11:0] r;
    s = a[11] ^ b[11];
    if (b[10:0] == 11'd0) return {s, 11'h7FF};
    if (a[10:0] == 11'd0) return 12'h000;
    ea = int'(a[10:6]); eb = int'(b[10:6]);
    ma = 64 + int'(a[5:0]); mb = 64 + int'(b[5:0]);
    e = ea - eb + 15;
    q = (ma * 256) / mb;
    if (q >= 256) m7 = (q / 2) % 128;
    else begin m7 = q % 128; e = e - 1; end
    if (e <= 0) return 12'h000;
    if (e > 31) return {s, 11'h7FF};
    v = e * 128 + m7;
    if (v / 2 == 2047) return {s, 11'h7FF};
    v = (v + 1) / 2;
    r = 12'(v);
    return {s, r[10:0]};
  endfunction

  function automatic bit is_special(input logic [11:0] a, input logic [11:0] b);
    return (a[10:0] == 11'd0) || (b[10:0] == 11'd0);
  endfunction

  // Launch one operation; returns the quotient and the number of edges from accept (inclusive) to valid_o.
  task automatic run_op(input logic [11:0] a, input logic [11:0] b,
                        output logic [11:0] res, output int lat);
    int w;
    @(negedge clk);
    data_1 = a; data_2 = b; valid_i = 1'b1;
    w = 0;
    while (!ready_o && w < 100) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 40) begin
      if (ready_o) busy_viol++;
      @(posedge clk); #1;
      lat++;
    end
    if (ready_o) busy_viol++;
    res = data_div;
  endtask

  task automatic finish_hs(input string tag);
    @(posedge clk); #1;
    check({tag, "_vld_drop"}, {31'd0, valid_o}, 32'd0);
    check({tag, "_rdy_back"}, {31'd0, ready_o}, 32'd1);
  endtask

  task automatic do_check(input string tag, input logic [11:0] a, input logic [11:0] b,
                          input logic [11:0] exp_res);
    logic [11:0] res;
    int lat;
    run_op(a, b, res, lat);
    check({tag, "_res"}, {20'd0, res}, {20'd0, exp_res});
    check({tag, "_lat"}, lat, is_special(a, b) ? SPECIAL_LAT : 11);
    finish_hs(tag);
  endtask

  initial begin
    logic [11:0] res, held, a, b;
    int lat, bad;

    #3;
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_data", {20'd0, data_div}, 32'd0);
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    #10 rst_n = 1'b1;

    do_check("t1_6div2", 12'h460, 12'h400, 12'h420);
    check("t1_busy_ready", busy_viol, 0);
    do_check("t2_1div3", 12'h3C0, 12'h420, 12'h355);
    do_check("t2_neg", 12'hC60, 12'h400, 12'hC20);
    do_check("t3_divz_pos", 12'h3C0, 12'h000, 12'h7FF);
    do_check("t3_divz_neg", 12'hBC0, 12'h000, 12'hFFF);
    do_check("t3_zero_num", 12'h000, 12'h420, 12'h000);
    do_check("t3_both_zero", 12'h800, 12'h000, 12'hFFF);
    do_check("t4_overflow", 12'h7C0, 12'h040, 12'h7FF);
    do_check("t4_underflow", 12'h040, 12'h7C0, 12'h000);
    do_check("t4_neg_flush", 12'h840, 12'h7C0, 12'h000);

    // Back-pressure: result must be held while ready_i is low.
    ready_i = 1'b0;
    run_op(12'h460, 12'h400, held, lat);
    check("t5_res", {20'd0, held}, 32'h420);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (data_div !== held || valid_o !== 1'b1 || ready_o !== 1'b0) bad++;
    end
    check("t5_hold", bad, 0);
    @(negedge clk);
    ready_i = 1'b1;
    finish_hs("t5");

    // Reset during the fourth DIV iteration.
    @(negedge clk);
    data_1 = 12'h460; data_2 = 12'h400; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, valid_o}, 32'd0);
    check("t6_rst_ready", {31'd0, ready_o}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (valid_o !== 1'b0) bad++;
    end
    check("t6_no_result", bad, 0);
    do_check("t6_after", 12'h460, 12'h400, 12'h420);

    // Random operands against the reference; some forced zeros.
    for (int i = 0; i < 40; i++) begin
      a = 12'($urandom);
      b = 12'($urandom);
      if ($urandom_range(0, 9) == 0) a[10:0] = 11'd0;
      if ($urandom_range(0, 9) == 0) b[10:0] = 11'd0;
      run_op(a, b, res, lat);
      check($sformatf("rnd%0d_%03h_%03h_res", i, a, b), {20'd0, res}, {20'd0, model(a, b)});
      check($sformatf("rnd%0d_lat", i), lat, is_special(a, b) ? SPECIAL_LAT : 11);
      @(posedge clk); #1;
    end

    check("busy_ready_total", busy_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
